// File: rtl/zap_wb_initiator_if.sv
// Wishbone B3 bus bundle shared by the initiator and any slave it drives.
// The master side owns the cycle qualifiers, address, byte enables, write data and cycle type.
// The slave side returns read data and the acknowledge.
interface zap_wb_initiator_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] masterDat;
    logic [2:0]  cti;
    logic [31:0] slaveDat;
    logic        ack;

    modport master (
        output cyc, stb, we, adr, sel, masterDat, cti,
        input  slaveDat, ack
    );

    modport slave (
        input  cyc, stb, we, adr, sel, masterDat, cti,
        output slaveDat, ack
    );
endinterface

// File: rtl/zap_wb_initiator.sv
// Wishbone B3 initiator: turns word-level read/write commands of 1..2**LEN_W beats into
// classic or incrementing-burst cycles. An ack watchdog aborts a stalled cycle.
// Every output is registered. The next-state logic computes the complete next register image.
module zap_wb_initiator #(
    parameter int LEN_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_we,
    input  logic [31:0]      i_cmd_adr,
    input  logic [3:0]       i_cmd_sel,
    input  logic [LEN_W-1:0] i_cmd_len,
    input  logic             i_wdat_valid,
    output logic             o_wdat_ready,
    input  logic [31:0]      i_wdat,
    output logic             o_rdat_valid,
    output logic [31:0]      o_rdat,
    output logic             o_done,
    output logic             o_err,
    zap_wb_initiator_if.master io_wb
);

    localparam int               WD_W      = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [2:0]       CTI_CLASS = 3'b000;
    localparam logic [2:0]       CTI_INCR  = 3'b010;
    localparam logic [2:0]       CTI_END   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WDAT,
        S_XFER
    } state_t;

    state_t           r_state,     w_state;
    logic             r_cmdReady,  w_cmdReady;
    logic             r_wdatReady, w_wdatReady;
    logic             r_cyc,       w_cyc;
    logic             r_stb,       w_stb;
    logic             r_we,        w_we;
    logic [31:0]      r_adr,       w_adr;
    logic [3:0]       r_sel,       w_sel;
    logic [31:0]      r_dat,       w_dat;
    logic [2:0]       r_cti,       w_cti;
    logic [31:0]      r_rdat,      w_rdat;
    logic             r_rdatValid, w_rdatValid;
    logic             r_done,      w_done;
    logic             r_err,       w_err;
    logic [LEN_W-1:0] r_beatsLeft, w_beatsLeft;
    logic [WD_W-1:0]  r_wdogCnt,   w_wdogCnt;
    logic             w_ack;

    // An ack only counts while a strobe is actually on the bus.
    assign w_ack = r_stb & io_wb.ack;

    // Next-state and next-output logic; every register holds unless a transition says otherwise.
    always_comb begin
        w_state     = r_state;
        w_cmdReady  = r_cmdReady;
        w_wdatReady = r_wdatReady;
        w_cyc       = r_cyc;
        w_stb       = r_stb;
        w_we        = r_we;
        w_adr       = r_adr;
        w_sel       = r_sel;
        w_dat       = r_dat;
        w_cti       = r_cti;
        w_rdat      = r_rdat;
        w_rdatValid = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_beatsLeft = r_beatsLeft;
        w_wdogCnt   = r_wdogCnt;

        case (r_state)
            S_IDLE: begin
                w_cmdReady  = 1'b1;
                w_cyc       = 1'b0;
                w_stb       = 1'b0;
                w_wdatReady = 1'b0;
                if (i_cmd_valid && r_cmdReady) begin
                    w_cmdReady  = 1'b0;
                    w_we        = i_cmd_we;
                    w_sel       = i_cmd_sel;
                    w_adr       = i_cmd_adr & 32'hFFFF_FFFC;
                    w_beatsLeft = i_cmd_len;
                    w_cti       = (i_cmd_len == '0) ? CTI_CLASS : CTI_INCR;
                    w_cyc       = 1'b1;
                    w_wdogCnt   = '0;
                    if (i_cmd_we) begin
                        w_wdatReady = 1'b1;
                        w_state     = S_WDAT;
                    end else begin
                        w_stb   = 1'b1;
                        w_state = S_XFER;
                    end
                end
            end

            S_WDAT: begin
                if (i_wdat_valid && r_wdatReady) begin
                    w_dat       = i_wdat;
                    w_wdatReady = 1'b0;
                    w_stb       = 1'b1;
                    w_wdogCnt   = '0;
                    w_state     = S_XFER;
                end
            end

            S_XFER: begin
                if (w_ack) begin
                    w_wdogCnt = '0;
                    if (!r_we) begin
                        w_rdat      = io_wb.slaveDat;
                        w_rdatValid = 1'b1;
                    end
                    if (r_beatsLeft != '0) begin
                        w_adr       = r_adr + 32'd4;
                        w_beatsLeft = r_beatsLeft - LEN_W'(1);
                        w_cti       = (r_beatsLeft == LEN_W'(1)) ? CTI_END : CTI_INCR;
                        if (r_we) begin
                            w_stb       = 1'b0;
                            w_wdatReady = 1'b1;
                            w_state     = S_WDAT;
                        end
                    end else begin
                        w_cyc      = 1'b0;
                        w_stb      = 1'b0;
                        w_we       = 1'b0;
                        w_cti      = CTI_CLASS;
                        w_done     = 1'b1;
                        w_cmdReady = 1'b1;
                        w_state    = S_IDLE;
                    end
                end else if (r_wdogCnt == WD_LAST) begin
                    w_cyc       = 1'b0;
                    w_stb       = 1'b0;
                    w_we        = 1'b0;
                    w_cti       = CTI_CLASS;
                    w_done      = 1'b1;
                    w_err       = 1'b1;
                    w_cmdReady  = 1'b1;
                    w_wdatReady = 1'b0;
                    w_state     = S_IDLE;
                end else begin
                    w_wdogCnt = r_wdogCnt + WD_W'(1);
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the bus immediately and suppresses done/err.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_cmdReady  <= 1'b0;
            r_wdatReady <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_sel       <= '0;
            r_dat       <= '0;
            r_cti       <= '0;
            r_rdat      <= '0;
            r_rdatValid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_beatsLeft <= '0;
            r_wdogCnt   <= '0;
        end else begin
            r_state     <= w_state;
            r_cmdReady  <= w_cmdReady;
            r_wdatReady <= w_wdatReady;
            r_cyc       <= w_cyc;
            r_stb       <= w_stb;
            r_we        <= w_we;
            r_adr       <= w_adr;
            r_sel       <= w_sel;
            r_dat       <= w_dat;
            r_cti       <= w_cti;
            r_rdat      <= w_rdat;
            r_rdatValid <= w_rdatValid;
            r_done      <= w_done;
            r_err       <= w_err;
            r_beatsLeft <= w_beatsLeft;
            r_wdogCnt   <= w_wdogCnt;
        end
    end

    assign o_cmd_ready     = r_cmdReady;
    assign o_wdat_ready    = r_wdatReady;
    assign o_rdat_valid    = r_rdatValid;
    assign o_rdat          = r_rdat;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign io_wb.cyc       = r_cyc;
    assign io_wb.stb       = r_stb;
    assign io_wb.we        = r_we;
    assign io_wb.adr       = r_adr;
    assign io_wb.sel       = r_sel;
    assign io_wb.masterDat = r_dat;
    assign io_wb.cti       = r_cti;

endmodule

// File: tb/tb_zap_wb_initiator.sv
// Directed bench for zap_wb_initiator. A RAM-model slave acks beats (optionally with stalls)
// and checks each beat against a queue of expected beats. A monitor checks read data
// against a queue of expected words.
module tb_zap_wb_initiator;

    localparam int LEN_W      = 3;
    localparam int TIMEOUT    = 64;
    localparam int MODE_FAST  = 0;
    localparam int MODE_STALL = 1;
    localparam int MODE_NEVER = 2;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    logic             clk;
    logic             rstN;
    logic             cmdValid;
    logic             cmdReady;
    logic             cmdWe;
    logic [31:0]      cmdAdr;
    logic [3:0]       cmdSel;
    logic [LEN_W-1:0] cmdLen;
    logic             wdatValid;
    logic             wdatReady;
    logic [31:0]      wdat;
    logic             rdatValid;
    logic [31:0]      rdat;
    logic             done;
    logic             err;

    zap_wb_initiator_if wbIf();

    int          checks = 0;
    int          failures = 0;
    int          slaveMode = MODE_FAST;
    int          waitCnt = 0;
    int          rdatSeen = 0;
    beat_t       expBeats[$];
    logic [31:0] expRdat[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] wrData[8];

    zap_wb_initiator #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_reset_n    (rstN),
        .i_cmd_valid  (cmdValid),
        .o_cmd_ready  (cmdReady),
        .i_cmd_we     (cmdWe),
        .i_cmd_adr    (cmdAdr),
        .i_cmd_sel    (cmdSel),
        .i_cmd_len    (cmdLen),
        .i_wdat_valid (wdatValid),
        .o_wdat_ready (wdatReady),
        .i_wdat       (wdat),
        .o_rdat_valid (rdatValid),
        .o_rdat       (rdat),
        .o_done       (done),
        .o_err        (err),
        .io_wb        (wbIf)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case some bounded wait was written wrongly.
    initial begin
        #300000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    // Every comparison goes through here so the counts stay in one place.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic memWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = memRead(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        mem[a] = w;
    endtask

    // RAM-model slave: acks one beat per strobe (after an optional stall), checking it against the queue.
    initial begin
        beat_t       e;
        logic [31:0] a;
        wbIf.ack      = 1'b0;
        wbIf.slaveDat = 32'h0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                wbIf.ack = 1'b0;
                waitCnt  = 0;
            end else if (wbIf.ack) begin
                wbIf.ack = 1'b0;
            end else if (wbIf.cyc && wbIf.stb && slaveMode != MODE_NEVER) begin
                if (waitCnt > 0) begin
                    waitCnt--;
                end else begin
                    a = {wbIf.adr[31:2], 2'b00};
                    checkOutput("beat_pending", 32'(expBeats.size() > 0), 32'd1);
                    if (expBeats.size() > 0) begin
                        e = expBeats.pop_front();
                        checkOutput($sformatf("beat_adr@%08h", e.adr), wbIf.adr, e.adr);
                        checkOutput($sformatf("beat_cti@%08h", e.adr), 32'(wbIf.cti), 32'(e.cti));
                        checkOutput($sformatf("beat_we@%08h", e.adr), 32'(wbIf.we), 32'(e.we));
                        checkOutput($sformatf("beat_sel@%08h", e.adr), 32'(wbIf.sel), 32'(e.sel));
                        if (e.we) checkOutput($sformatf("beat_dat@%08h", e.adr), wbIf.masterDat, e.dat);
                    end
                    if (wbIf.we) memWrite(a, wbIf.masterDat, wbIf.sel);
                    else         wbIf.slaveDat = memRead(a);
                    wbIf.ack = 1'b1;
                    waitCnt  = (slaveMode == MODE_STALL) ? int'($urandom_range(0, 3)) : 0;
                end
            end
        end
    end

    // Read-data monitor: every rdat pulse must match the next expected word, in order.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rstN && rdatValid) begin
                rdatSeen++;
                checkOutput("rdat_pending", 32'(expRdat.size() > 0), 32'd1);
                if (expRdat.size() > 0) begin
                    e = expRdat.pop_front();
                    checkOutput("rdat_value", rdat, e);
                end
            end
        end
    end

    // Issue one command and push the beats/data it must produce; returns one negedge after accept.
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                 input int len, input bit pushExp);
        beat_t       b;
        logic [31:0] base;
        int          n;
        base = adr & 32'hFFFF_FFFC;
        if (pushExp) begin
            for (int i = 0; i <= len; i++) begin
                b.adr = base + 32'(i * 4);
                b.cti = (len == 0) ? 3'b000 : ((i == len) ? 3'b111 : 3'b010);
                b.we  = we;
                b.sel = sel;
                b.dat = we ? wrData[i] : 32'h0;
                expBeats.push_back(b);
                if (!we) expRdat.push_back(memRead(b.adr));
            end
        end
        n = 0;
        while (!cmdReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_ready_wait", 32'(cmdReady), 32'd1);
        cmdValid = 1'b1;
        cmdWe    = we;
        cmdAdr   = adr;
        cmdSel   = sel;
        cmdLen   = LEN_W'(len);
        @(negedge clk);
        cmdValid = 1'b0;
    endtask

    // Feed write beats after a delay, checking that stb stays low while waiting for data.
    task automatic writeBeats(input int len, input int delay);
        int n;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (!wdatReady && n < 100) begin
                @(negedge clk);
                n++;
            end
            checkOutput($sformatf("wdat_ready_%0d", i), 32'(wdatReady), 32'd1);
            for (int d = 0; d < delay; d++) begin
                checkOutput($sformatf("wdat_stb_low_%0d_%0d", i, d), 32'(wbIf.stb), 32'd0);
                checkOutput($sformatf("wdat_cyc_high_%0d_%0d", i, d), 32'(wbIf.cyc), 32'd1);
                @(negedge clk);
            end
            wdatValid = 1'b1;
            wdat      = wrData[i];
            @(negedge clk);
            wdatValid = 1'b0;
        end
    endtask

    // Wait (bounded) for done, then check the end-of-command state and that cyc never dropped.
    task automatic waitDone(input string tag, input logic expErr);
        int n;
        int gaps;
        n    = 0;
        gaps = 0;
        while (!done && n < 400) begin
            if (!wbIf.cyc) gaps++;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
        checkOutput({tag, "_cyc_gaps"}, 32'(gaps), 32'd0);
        checkOutput({tag, "_cyc_end"}, 32'(wbIf.cyc), 32'd0);
        checkOutput({tag, "_ready_with_done"}, 32'(cmdReady), 32'd1);
        #1;
        checkOutput({tag, "_beats_left"}, 32'(expBeats.size()), 32'd0);
        checkOutput({tag, "_rdat_left"}, 32'(expRdat.size()), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    // Directed sequence: reset, the six scenarios, then the summary.
    initial begin
        int          cnt;
        int          startSeen;
        logic [31:0] old0;
        logic [31:0] old1;

        rstN      = 1'b0;
        cmdValid  = 1'b0;
        cmdWe     = 1'b0;
        cmdAdr    = 32'h0;
        cmdSel    = 4'h0;
        cmdLen    = '0;
        wdatValid = 1'b0;
        wdat      = 32'h0;

        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd0);
        checkOutput("rst_cyc", 32'(wbIf.cyc), 32'd0);
        checkOutput("rst_stb", 32'(wbIf.stb), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_rdat_valid", 32'(rdatValid), 32'd0);
        checkOutput("rst_adr", wbIf.adr, 32'h0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst_release_ready", 32'(cmdReady), 32'd1);

        $display("[TB] single read");
        mem[32'h100] = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 32'h0000_0100, 4'hF, 0, 1'b1);
        waitDone("single_read", 1'b0);
        checkOutput("single_read_data", rdat, 32'hDEAD_BEEF);

        $display("[TB] read burst");
        applyStimulus(1'b0, 32'h0000_0200, 4'hF, 3, 1'b1);
        waitDone("burst_read", 1'b0);

        $display("[TB] write with delayed data");
        old0 = memRead(32'h300);
        old1 = memRead(32'h304);
        wrData[0] = 32'h1122_3344;
        wrData[1] = 32'h5566_7788;
        applyStimulus(1'b1, 32'h0000_0300, 4'h3, 1, 1'b1);
        writeBeats(1, 3);
        waitDone("write", 1'b0);
        checkOutput("write_mem0", memRead(32'h300), {old0[31:16], 16'h3344});
        checkOutput("write_mem1", memRead(32'h304), {old1[31:16], 16'h7788});

        $display("[TB] watchdog");
        slaveMode = MODE_NEVER;
        applyStimulus(1'b0, 32'h0000_0500, 4'hF, 2, 1'b0);
        cnt = 0;
        while (wbIf.stb && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("wdog_stb_cycles", 32'(cnt), 32'(TIMEOUT));
        checkOutput("wdog_cyc", 32'(wbIf.cyc), 32'd0);
        checkOutput("wdog_done", 32'(done), 32'd1);
        checkOutput("wdog_err", 32'(err), 32'd1);
        checkOutput("wdog_ready", 32'(cmdReady), 32'd1);
        @(negedge clk);
        checkOutput("wdog_done_pulse", 32'(done), 32'd0);
        checkOutput("wdog_err_pulse", 32'(err), 32'd0);
        slaveMode = MODE_FAST;

        $display("[TB] address wrap burst");
        applyStimulus(1'b0, 32'hFFFF_FFF8, 4'hF, 2, 1'b1);
        waitDone("wrap_read", 1'b0);

        $display("[TB] reset mid-burst");
        slaveMode = MODE_STALL;
        startSeen = rdatSeen;
        applyStimulus(1'b0, 32'h0000_0400, 4'hF, 3, 1'b1);
        cnt = 0;
        while (rdatSeen == startSeen && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("midrst_first_beat", 32'(rdatSeen - startSeen), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midrst_cyc", 32'(wbIf.cyc), 32'd0);
        checkOutput("midrst_stb", 32'(wbIf.stb), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        expBeats.delete();
        expRdat.delete();
        repeat (2) @(negedge clk);
        checkOutput("midrst_hold_cyc", 32'(wbIf.cyc), 32'd0);
        rstN = 1'b1;
        slaveMode = MODE_FAST;
        @(negedge clk);
        checkOutput("midrst_ready", 32'(cmdReady), 32'd1);
        applyStimulus(1'b0, 32'h0000_0600, 4'h5, 1, 1'b1);
        waitDone("post_reset_read", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
